rw_reg_bank: RTL and testbench

- Parametrised bank of NUM_REG mode-gated read/write control registers at consecutive addresses from BASE_ADDR.
- Each register stores a data word plus a CRC word.
- Successor to the single-register block: adds a registered read path with valid, per-register access masks, a key-sequence write-lock FSM, and access-error reporting.
- Sits between the SPI/frame decoder and the analog/digital control fabric.

---
 rtl/rw_reg_bank_pkg.sv | 22 ++
 rtl/rw_reg_bank_lock_fsm.sv | 62 ++++++
 rtl/rw_reg_bank.sv | 210 +++++++++++++++++++++
 tb/tb_rw_reg_bank.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rw_reg_bank_pkg.sv
// ============================================================================
// Module : rw_reg_bank_pkg
// Desc   : Shared types and key constants for the rw_reg_bank register block.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rw_reg_bank_pkg;

    typedef enum logic [1:0] {
        UNLOCKED  = 2'd0,
        KEY1_WAIT = 2'd1,
        LOCKED    = 2'd2
    } lock_state_e;

    localparam logic [7:0] LOCK_KEY0  = 8'h5A;
    localparam logic [7:0] LOCK_KEY1  = 8'hA5;
    localparam logic [7:0] UNLOCK_KEY = 8'hC3;

endpackage

`default_nettype wire

// File: rtl/rw_reg_bank_lock_fsm.sv
// ============================================================================
// Module : rw_reg_bank_lock_fsm
// Desc   : Two-key write-lock sequencer; unlock only from test mode.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rw_reg_bank_lock_fsm
    import rw_reg_bank_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_lock_wr,
    input  logic       i_any_wr,
    input  logic [7:0] i_wdata_lo,
    input  logic       i_test_mode,
    output logic       o_locked,
    output logic       o_lock_deny
);

    lock_state_e r_state;
    lock_state_e w_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= UNLOCKED;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            UNLOCKED: begin
                if (i_lock_wr && (i_wdata_lo == LOCK_KEY0)) begin
                    w_next = KEY1_WAIT;
                end
            end
            KEY1_WAIT: begin
                // The second key must be the very next write, wherever it lands
                if (i_any_wr) begin
                    w_next = (i_lock_wr && (i_wdata_lo == LOCK_KEY1)) ? LOCKED : UNLOCKED;
                end
            end
            LOCKED: begin
                if (i_lock_wr && i_test_mode && (i_wdata_lo == UNLOCK_KEY)) begin
                    w_next = UNLOCKED;
                end
            end
            default: w_next = UNLOCKED;
        endcase
    end

    always_comb begin
        o_locked    = (r_state == LOCKED);
        o_lock_deny = (r_state == LOCKED) && i_lock_wr && !i_test_mode;
    end

endmodule

`default_nettype wire

// File: rtl/rw_reg_bank.sv
// ============================================================================
// Module : rw_reg_bank
// Desc   : Mode-gated R/W register bank with CRC, access masks, key lock and
//          error reporting. Optional parity: define RW_REG_BANK_PARITY_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rw_reg_bank
    import rw_reg_bank_pkg::*;
#(
    parameter int                       DW           = 8,
    parameter int                       AW           = 8,
    parameter int                       CRC_W        = 8,
    parameter int                       NUM_REG      = 4,
    parameter logic [AW-1:0]            BASE_ADDR    = {AW{1'b0}},
    parameter logic [NUM_REG*DW-1:0]    DEFAULT_VAL  = {NUM_REG*DW{1'b0}},
    parameter logic [NUM_REG-1:0]       TEST_WR_MASK = {NUM_REG{1'b1}},
    parameter logic [NUM_REG-1:0]       TEST_RD_MASK = {NUM_REG{1'b1}},
    parameter logic [NUM_REG-1:0]       CFG_WR_MASK  = {NUM_REG{1'b1}},
    parameter logic [NUM_REG-1:0]       CFG_RD_MASK  = {NUM_REG{1'b1}},
    parameter int                       ERR_CNT_W    = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_wen,
    input  logic                    i_ren,
    input  logic                    i_test_mode_status,
    input  logic                    i_cfg_mode_status,
    input  logic [AW-1:0]           i_addr,
    input  logic [DW-1:0]           i_wdata,
    input  logic [CRC_W-1:0]        i_crc_data,
    output logic [DW-1:0]           o_rdata,
    output logic [CRC_W-1:0]        o_rcrc,
    output logic                    o_rvld,
    output logic [NUM_REG*DW-1:0]   o_reg_data,
    output logic                    o_locked,
    output logic                    o_err,
    output logic [ERR_CNT_W-1:0]    o_err_cnt
`ifdef RW_REG_BANK_PARITY_EN
    ,
    output logic                    o_par_err
`endif
);

    // One extra address bit keeps the range check exact when the bank ends at the top
    localparam logic [AW:0] c_base      = {1'b0, BASE_ADDR};
    localparam logic [AW:0] c_num       = (AW+1)'(NUM_REG);
    localparam logic [AW:0] c_lock_addr = c_base + c_num;

    logic [AW:0]          w_addr_ext;
    logic [AW:0]          w_off;
    logic                 w_reg_hit;
    logic                 w_lock_hit;
    logic                 w_mode_any;
    logic                 w_locked;
    logic                 w_lock_deny;
    logic [NUM_REG-1:0]   w_sel;
    logic [NUM_REG-1:0]   w_wr_perm;
    logic [NUM_REG-1:0]   w_rd_perm;
    logic [DW-1:0]        w_rd_data;
    logic [CRC_W-1:0]     w_rd_crc;
    logic                 w_deny;
    logic                 w_cnt_inc;

    logic [DW-1:0]        r_data [NUM_REG];
    logic [CRC_W-1:0]     r_crc  [NUM_REG];
    logic [DW-1:0]        r_rdata;
    logic [CRC_W-1:0]     r_rcrc;
    logic                 r_rvld;
    logic                 r_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    assign w_addr_ext = {1'b0, i_addr};
    assign w_off      = w_addr_ext - c_base;
    assign w_reg_hit  = (w_addr_ext >= c_base) && (w_off < c_num);
    assign w_lock_hit = (w_addr_ext == c_lock_addr);
    assign w_mode_any = i_test_mode_status | i_cfg_mode_status;

    rw_reg_bank_lock_fsm u_lock_fsm (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_lock_wr   (i_wen & w_lock_hit & w_mode_any),
        .i_any_wr    (i_wen),
        .i_wdata_lo  (i_wdata[7:0]),
        .i_test_mode (i_test_mode_status),
        .o_locked    (w_locked),
        .o_lock_deny (w_lock_deny)
    );

    for (genvar k = 0; k < NUM_REG; k++) begin : g_reg
        assign w_sel[k]     = w_reg_hit && (w_off == (AW+1)'(k));
        assign w_wr_perm[k] = (i_test_mode_status & TEST_WR_MASK[k]) |
                              (i_cfg_mode_status & CFG_WR_MASK[k] & ~w_locked);
        assign w_rd_perm[k] = (i_test_mode_status & TEST_RD_MASK[k]) |
                              (i_cfg_mode_status & CFG_RD_MASK[k]);

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_data[k] <= DEFAULT_VAL[k*DW +: DW];
                r_crc[k]  <= '0;
            end else if (i_wen && w_sel[k] && w_wr_perm[k]) begin
                r_data[k] <= i_wdata;
                r_crc[k]  <= i_crc_data;
            end
        end

        assign o_reg_data[k*DW +: DW] = r_data[k];
    end

    // Read mux and denial detection share the same decode
    always_comb begin
        w_rd_data = '0;
        w_rd_crc  = '0;
        w_deny    = 1'b0;
        for (int k = 0; k < NUM_REG; k++) begin
            if (w_sel[k]) begin
                if (i_wen && !w_wr_perm[k]) begin
                    w_deny = 1'b1;
                end
                if (i_ren) begin
                    if (w_rd_perm[k]) begin
                        w_rd_data = r_data[k];
                        w_rd_crc  = r_crc[k];
                    end else begin
                        w_deny = 1'b1;
                    end
                end
            end
        end
        if (w_lock_hit) begin
            if (i_wen && (!w_mode_any || w_lock_deny)) begin
                w_deny = 1'b1;
            end
            if (i_ren) begin
                if (w_mode_any) begin
                    w_rd_data = {{(DW-1){1'b0}}, w_locked};
                end else begin
                    w_deny = 1'b1;
                end
            end
        end
    end

`ifdef RW_REG_BANK_PARITY_EN
    logic [NUM_REG-1:0] r_par;
    logic               w_par_bad;
    logic               r_par_err;

    for (genvar k = 0; k < NUM_REG; k++) begin : g_par
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_par[k] <= ^DEFAULT_VAL[k*DW +: DW];
            end else if (i_wen && w_sel[k] && w_wr_perm[k]) begin
                r_par[k] <= ^i_wdata;
            end
        end
    end

    always_comb begin
        w_par_bad = 1'b0;
        for (int k = 0; k < NUM_REG; k++) begin
            if (i_ren && w_sel[k] && w_rd_perm[k] && (r_par[k] != ^r_data[k])) begin
                w_par_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= w_par_bad;
        end
    end

    assign o_par_err = r_par_err;
    assign w_cnt_inc = w_deny | w_par_bad;
`else
    assign w_cnt_inc = w_deny;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata   <= '0;
            r_rcrc    <= '0;
            r_rvld    <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_rvld  <= i_ren;
            r_rdata <= i_ren ? w_rd_data : '0;
            r_rcrc  <= i_ren ? w_rd_crc : '0;
            r_err   <= w_deny;
            if (w_cnt_inc && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign o_rdata   = r_rdata;
    assign o_rcrc    = r_rcrc;
    assign o_rvld    = r_rvld;
    assign o_err     = r_err;
    assign o_err_cnt = r_err_cnt;
    assign o_locked  = w_locked;

endmodule

`default_nettype wire

// File: tb/tb_rw_reg_bank.sv
// ============================================================================
// Module : tb_rw_reg_bank
// Desc   : Directed self-checking bench for rw_reg_bank (base 0x10, lock 0x14).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rw_reg_bank;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_wen;
    logic        i_ren;
    logic        i_test_mode_status;
    logic        i_cfg_mode_status;
    logic [7:0]  i_addr;
    logic [7:0]  i_wdata;
    logic [7:0]  i_crc_data;
    logic [7:0]  o_rdata;
    logic [7:0]  o_rcrc;
    logic        o_rvld;
    logic [31:0] o_reg_data;
    logic        o_locked;
    logic        o_err;
    logic [3:0]  o_err_cnt;
`ifdef RW_REG_BANK_PARITY_EN
    logic        o_par_err;
`endif

    int total = 0;
    int bad   = 0;

    rw_reg_bank #(
        .DW           (8),
        .AW           (8),
        .CRC_W        (8),
        .NUM_REG      (4),
        .BASE_ADDR    (8'h10),
        .DEFAULT_VAL  (32'h44332211),
        .TEST_WR_MASK (4'b1111),
        .TEST_RD_MASK (4'b1110),
        .CFG_WR_MASK  (4'b0111),
        .CFG_RD_MASK  (4'b1111),
        .ERR_CNT_W    (4)
    ) dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_wen              (i_wen),
        .i_ren              (i_ren),
        .i_test_mode_status (i_test_mode_status),
        .i_cfg_mode_status  (i_cfg_mode_status),
        .i_addr             (i_addr),
        .i_wdata            (i_wdata),
        .i_crc_data         (i_crc_data),
        .o_rdata            (o_rdata),
        .o_rcrc             (o_rcrc),
        .o_rvld             (o_rvld),
        .o_reg_data         (o_reg_data),
        .o_locked           (o_locked),
        .o_err              (o_err),
        .o_err_cnt          (o_err_cnt)
`ifdef RW_REG_BANK_PARITY_EN
        ,
        .o_par_err          (o_par_err)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One access cycle; outputs are sampled 1ns after the capturing edge
    task automatic acc(input logic wen, input logic ren, input logic [7:0] addr,
                       input logic [7:0] wdata, input logic [7:0] crc);
        i_wen      = wen;
        i_ren      = ren;
        i_addr     = addr;
        i_wdata    = wdata;
        i_crc_data = crc;
        @(posedge i_clk);
        #1;
        i_wen = 1'b0;
        i_ren = 1'b0;
    endtask

    task automatic set_mode(input logic test, input logic cfg);
        i_test_mode_status = test;
        i_cfg_mode_status  = cfg;
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_wen = 1'b0; i_ren = 1'b0; i_addr = '0; i_wdata = '0; i_crc_data = '0;
        set_mode(1'b0, 1'b0);
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_reg_data", o_reg_data, 32'h44332211);
        check("rst_rvld",     {31'd0, o_rvld}, 32'd0);
        check("rst_err_cnt",  {28'd0, o_err_cnt}, 32'd0);
        check("rst_locked",   {31'd0, o_locked}, 32'd0);
        check("rst_rdata",    {24'd0, o_rdata}, 32'd0);
        i_rst_n = 1'b1;

        // cfg write/read of register 2
        set_mode(1'b0, 1'b1);
        acc(1, 0, 8'h12, 8'hAB, 8'h3C);
        check("wr_reg2_data", o_reg_data, 32'h44AB2211);
        check("wr_reg2_err",  {31'd0, o_err}, 32'd0);
        acc(0, 1, 8'h12, 8'h00, 8'h00);
        check("rd_reg2_vld",  {31'd0, o_rvld}, 32'd1);
        check("rd_reg2_data", {24'd0, o_rdata}, 32'h000000AB);
        check("rd_reg2_crc",  {24'd0, o_rcrc}, 32'h0000003C);
        acc(0, 0, 8'h00, 8'h00, 8'h00);
        check("idle_vld",     {31'd0, o_rvld}, 32'd0);
        check("idle_rdata",   {24'd0, o_rdata}, 32'd0);
        check("idle_rcrc",    {24'd0, o_rcrc}, 32'd0);

        acc(0, 1, 8'h10, 8'h00, 8'h00);
        check("rd_reg0_data", {24'd0, o_rdata}, 32'h00000011);
        check("rd_reg0_crc",  {24'd0, o_rcrc}, 32'd0);

        // miss: valid response, zero data, no error
        acc(0, 1, 8'h20, 8'h00, 8'h00);
        check("miss_vld",   {31'd0, o_rvld}, 32'd1);
        check("miss_rdata", {24'd0, o_rdata}, 32'd0);
        check("miss_err",   {31'd0, o_err}, 32'd0);

        // reg3 not writable in cfg mode
        acc(1, 0, 8'h13, 8'h99, 8'h00);
        check("cfgmask_err",  {31'd0, o_err}, 32'd1);
        check("cfgmask_cnt",  {28'd0, o_err_cnt}, 32'd1);
        check("cfgmask_data", o_reg_data, 32'h44AB2211);
        acc(0, 0, 8'h00, 8'h00, 8'h00);
        check("err_one_cycle", {31'd0, o_err}, 32'd0);

        // lock sequence in cfg mode
        acc(1, 0, 8'h14, 8'h5A, 8'h00);
        check("key0_locked", {31'd0, o_locked}, 32'd0);
        acc(1, 0, 8'h14, 8'hA5, 8'h00);
        check("key1_locked", {31'd0, o_locked}, 32'd1);
        acc(0, 1, 8'h14, 8'h00, 8'h00);
        check("rd_lock_data", {24'd0, o_rdata}, 32'h00000001);
        check("rd_lock_crc",  {24'd0, o_rcrc}, 32'd0);
        acc(1, 0, 8'h10, 8'h77, 8'h00);
        check("locked_wr_data", o_reg_data, 32'h44AB2211);
        check("locked_wr_err",  {31'd0, o_err}, 32'd1);
        check("locked_wr_cnt",  {28'd0, o_err_cnt}, 32'd2);
        acc(1, 0, 8'h14, 8'hC3, 8'h00);
        check("cfg_unlock_err",    {31'd0, o_err}, 32'd1);
        check("cfg_unlock_locked", {31'd0, o_locked}, 32'd1);
        check("cfg_unlock_cnt",    {28'd0, o_err_cnt}, 32'd3);

        // unlock from test mode
        set_mode(1'b1, 1'b0);
        acc(1, 0, 8'h14, 8'hC3, 8'h00);
        check("test_unlock_locked", {31'd0, o_locked}, 32'd0);
        check("test_unlock_err",    {31'd0, o_err}, 32'd0);

        // interrupted key sequence does not lock
        set_mode(1'b0, 1'b1);
        acc(1, 0, 8'h14, 8'h5A, 8'h00);
        acc(1, 0, 8'h11, 8'h66, 8'h00);
        acc(1, 0, 8'h14, 8'hA5, 8'h00);
        check("intr_locked", {31'd0, o_locked}, 32'd0);
        check("intr_data",   o_reg_data, 32'h44AB6611);

        // a read between keys does not break the sequence
        acc(1, 0, 8'h14, 8'h5A, 8'h00);
        acc(0, 1, 8'h10, 8'h00, 8'h00);
        check("midkey_rdata", {24'd0, o_rdata}, 32'h00000011);
        acc(1, 0, 8'h14, 8'hA5, 8'h00);
        check("midkey_locked", {31'd0, o_locked}, 32'd1);
        set_mode(1'b1, 1'b0);
        acc(1, 0, 8'h14, 8'hC3, 8'h00);
        check("unlock2_locked", {31'd0, o_locked}, 32'd0);

        // test-mode writes to reg3, then same-cycle write/read
        acc(1, 0, 8'h13, 8'hFF, 8'h5E);
        check("wr_reg3_data", o_reg_data, 32'hFFAB6611);
        acc(1, 1, 8'h13, 8'h11, 8'h00);
        check("rw_same_rdata", {24'd0, o_rdata}, 32'h000000FF);
        check("rw_same_rcrc",  {24'd0, o_rcrc}, 32'h0000005E);
        check("rw_same_data",  o_reg_data, 32'h11AB6611);
`ifdef RW_REG_BANK_PARITY_EN
        check("par_err_clean", {31'd0, o_par_err}, 32'd0);
`endif

        // reg0 not readable in test mode
        acc(0, 1, 8'h10, 8'h00, 8'h00);
        check("testmask_vld",   {31'd0, o_rvld}, 32'd1);
        check("testmask_rdata", {24'd0, o_rdata}, 32'd0);
        check("testmask_err",   {31'd0, o_err}, 32'd1);
        check("testmask_cnt",   {28'd0, o_err_cnt}, 32'd4);

        // no mode active
        set_mode(1'b0, 1'b0);
        acc(0, 1, 8'h10, 8'h00, 8'h00);
        check("nomode_vld",   {31'd0, o_rvld}, 32'd1);
        check("nomode_rdata", {24'd0, o_rdata}, 32'd0);
        check("nomode_err",   {31'd0, o_err}, 32'd1);
        check("nomode_cnt",   {28'd0, o_err_cnt}, 32'd5);
        acc(1, 0, 8'h11, 8'h55, 8'h00);
        check("nomode_wr_data", o_reg_data, 32'h11AB6611);
        check("nomode_wr_cnt",  {28'd0, o_err_cnt}, 32'd6);

        // counter saturation
        for (int i = 0; i < 20; i++) begin
            acc(0, 1, 8'h12, 8'h00, 8'h00);
        end
        check("sat_cnt", {28'd0, o_err_cnt}, 32'h0000000F);
        check("sat_err", {31'd0, o_err}, 32'd1);

        // asynchronous reset while locked
        set_mode(1'b0, 1'b1);
        acc(1, 0, 8'h14, 8'h5A, 8'h00);
        acc(1, 0, 8'h14, 8'hA5, 8'h00);
        check("pre_arst_locked", {31'd0, o_locked}, 32'd1);
        #2 i_rst_n = 1'b0;
        #1;
        check("arst_locked",   {31'd0, o_locked}, 32'd0);
        check("arst_cnt",      {28'd0, o_err_cnt}, 32'd0);
        check("arst_reg_data", o_reg_data, 32'h44332211);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        // reset between keys abandons the half-entered sequence
        acc(1, 0, 8'h14, 8'h5A, 8'h00);
        #2 i_rst_n = 1'b0;
        #1 i_rst_n = 1'b1;
        acc(1, 0, 8'h14, 8'hA5, 8'h00);
        check("arst_key_locked", {31'd0, o_locked}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
